// File: rtl/piso_serializer.sv
// Word FIFO feeding a parallel-in/serial-out shifter; words leave back to back with no gap bits
// so bit patterns that straddle word boundaries reach the downstream detector intact.
module piso_serializer #(
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_BIT   = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          ser_out,
   output logic                          ser_valid,
   output logic                          word_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // No full-bypass: a full FIFO refuses a word even when a pop frees a slot on the same edge.
   assign in_ready = !rst && (fifo_count < CW'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (fifo_count != '0) && ((state == IDLE) || (bit_cnt == '0));
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // The shifter holds only the bits still to be sent; the current bit lives in ser_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         ser_out   <= IDLE_BIT;
         ser_valid <= 1'b0;
         word_done <= 1'b0;
      end else if (pop) begin
         state     <= SHIFT;
         shreg     <= advance(head);
         bit_cnt   <= BW'(WIDTH - 1);
         ser_out   <= first_bit(head);
         ser_valid <= 1'b1;
         word_done <= 1'b0;
      end else if ((state == SHIFT) && (bit_cnt != '0)) begin
         state     <= SHIFT;
         shreg     <= advance(shreg);
         bit_cnt   <= bit_cnt - 1'b1;
         ser_out   <= first_bit(shreg);
         ser_valid <= 1'b1;
         word_done <= (bit_cnt == BW'(1));
      end else begin
         state     <= IDLE;
         shreg     <= shreg;
         bit_cnt   <= '0;
         ser_out   <= IDLE_BIT;
         ser_valid <= 1'b0;
         word_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Drives two serializers (MSB-first/idle-0 and LSB-first/idle-1) with the same word stream and
// checks each against a word-list reference model through a decoupled scoreboard and monitor.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;

   logic       ir [2];
   logic       so [2];
   logic       sv [2];
   logic       wd [2];
   logic [2:0] fc [2];

   piso_serializer #(.WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
      .ser_out(so[0]), .ser_valid(sv[0]), .word_done(wd[0]), .fifo_count(fc[0])
   );

   piso_serializer #(.WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
      .ser_out(so[1]), .ser_valid(sv[1]), .word_done(wd[1]), .fifo_count(fc[1])
   );

   always #5 clk = ~clk;

   int         pass_cnt = 0;
   int         total_cnt = 0;
   logic [7:0] words [$];
   bit         rst_seen = 1'b0;
   int         started [2] = '{0, 0};
   int         bit_idx [2] = '{0, 0};
   bit         check_next [2] = '{1'b0, 1'b0};
   bit         expect_start [2] = '{1'b0, 1'b0};
   bit         log_a [$];
   bit         log_b [$];
   int         max_fc = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total_cnt++;
      if (actual == expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic longint pack(input bit q [$]);
      longint v = 0;
      foreach (q[k]) v = (v << 1) | longint'(q[k]);
      return v;
   endfunction

   function automatic bit has10110(input bit q [$]);
      for (int k = 0; k + 4 < q.size(); k++) begin
         if (q[k] && !q[k+1] && q[k+2] && q[k+3] && !q[k+4]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Scoreboard side: every accepted word (and every reset) updates the reference word list.
   always @(posedge clk) begin
      if (rst) begin
         words.delete();
         rst_seen = 1'b1;
      end else if (in_valid && ir[0]) begin
         words.push_back(in_data);
      end
   end

   // Monitor side: compares each instance's outputs with the word list between edges.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int         pending;
         logic [7:0] w;
         bit         exp_bit;
         bit         idle_bit;
         idle_bit = (i == 1);
         if (rst_seen) begin
            started[i]    = 0;
            bit_idx[i]    = 0;
            check_next[i] = 1'b0;
            checkOutput($sformatf("rst_valid%0d", i), int'(sv[i]), 0);
            checkOutput($sformatf("rst_idle%0d", i), int'(so[i]), int'(idle_bit));
            checkOutput($sformatf("rst_done%0d", i), int'(wd[i]), 0);
         end else begin
            if (check_next[i]) begin
               checkOutput($sformatf("start%0d", i), int'(sv[i]), int'(expect_start[i]));
            end
            if (sv[i]) begin
               if (bit_idx[i] == 0) begin
                  started[i]++;
               end
               if (started[i] > words.size()) begin
                  checkOutput($sformatf("extra_word%0d", i), started[i], words.size());
                  started[i] = words.size();
               end else begin
                  w       = words[started[i] - 1];
                  exp_bit = (i == 0) ? w[7 - bit_idx[i]] : w[bit_idx[i]];
                  checkOutput($sformatf("bit%0d", i), int'(so[i]), int'(exp_bit));
               end
               checkOutput($sformatf("word_done%0d", i), int'(wd[i]), int'(bit_idx[i] == 7));
               if (i == 0) log_a.push_back(so[i]);
               else        log_b.push_back(so[i]);
               bit_idx[i] = (bit_idx[i] + 1) % 8;
            end else begin
               checkOutput($sformatf("idle_out%0d", i), int'(so[i]), int'(idle_bit));
               checkOutput($sformatf("idle_done%0d", i), int'(wd[i]), 0);
               checkOutput($sformatf("gap%0d", i), bit_idx[i], 0);
            end
         end
         pending = words.size() - started[i];
         checkOutput($sformatf("fifo_count%0d", i), int'(fc[i]), pending);
         checkOutput($sformatf("in_ready%0d", i), int'(ir[i]), int'(!rst && pending < 4));
         if (int'(fc[i]) > max_fc && i == 0) max_fc = int'(fc[i]);
         check_next[i]   = !sv[i] || wd[i];
         expect_start[i] = pending > 0;
      end
      rst_seen = 1'b0;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] w);
      bit ok = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = ir[0];
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (!ok) checkOutput("handshake_timeout", 0, 1);
   endtask

   task automatic pulseReset();
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      log_a.delete(); log_b.delete();
      applyStimulus(8'hB0);
      idle(14);
      checkOutput("b0_msb", int'(pack(log_a)), 8'hB0);
      checkOutput("b0_lsb", int'(pack(log_b)), 8'h0D);
      checkOutput("b0_pattern", int'(has10110(log_a)), 1);

      log_a.delete(); log_b.delete();
      applyStimulus(8'h05);
      applyStimulus(8'h80);
      idle(22);
      checkOutput("pair_len", log_a.size(), 16);
      checkOutput("pair_bits", int'(pack(log_a)), 16'h0580);
      checkOutput("pair_pattern", int'(has10110(log_a)), 1);

      log_a.delete(); log_b.delete();
      applyStimulus(8'h0D);
      idle(14);
      checkOutput("0d_lsb", int'(pack(log_b)), 8'hB0);

      max_fc = 0;
      for (int k = 0; k < 6; k++) applyStimulus(8'(8'h31 + k * 8'h11));
      checkOutput("full_reached", max_fc, 4);
      idle(70);

      applyStimulus(8'hC3);
      applyStimulus(8'h5A);
      applyStimulus(8'hE7);
      for (int t = 0; t < 100 && bit_idx[0] != 3; t++) @(negedge clk);
      checkOutput("reach_bit3", bit_idx[0], 3);
      @(posedge clk);
      #1;
      pulseReset();
      idle(3);
      log_a.delete(); log_b.delete();
      applyStimulus(8'hA5);
      idle(14);
      checkOutput("post_rst_len", log_a.size(), 8);
      checkOutput("post_rst_word", int'(pack(log_a)), 8'hA5);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 39) == 0) pulseReset();
         idle($urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : 0);
         applyStimulus(8'($urandom));
      end
      idle(80);
      checkOutput("drain_a", started[0], words.size());
      checkOutput("drain_b", started[1], words.size());

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
